// File: rtl/ssp_pkg.sv
// Shared SSP package: default FIFO geometry, timeout length and a clog2 helper
// for tools that lack $clog2.
package ssp_pkg;

  localparam int SSP_DATA_W       = 32'sd8;
  localparam int SSP_RXFIFO_DEPTH = 32'sd8;
  localparam int SSP_RX_TIMEOUT   = 32'sd32;

  function automatic int clog2(input int value);
    int res;
    int rem;
    res = 32'sd0;
    rem = value - 32'sd1;
    while (rem > 32'sd0) begin
      res = res + 32'sd1;
      rem = rem >>> 32'sd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ssp_rx_fifo_wm_if.sv
// Shifter-side push and APB read-path signals of the SSP receive FIFO.
interface ssp_rx_fifo_wm_if
  import ssp_pkg::*;
#(
  parameter int DATA_W = SSP_DATA_W
);
  logic              PSEL;
  logic              PWRITE;
  logic [DATA_W-1:0] PRDATA;
  logic              rd_valid;
  logic [DATA_W-1:0] RxData;
  logic              write_ready;

  modport master (
    output PSEL, PWRITE, RxData, write_ready,
    input  PRDATA, rd_valid
  );

  modport slave (
    input  PSEL, PWRITE, RxData, write_ready,
    output PRDATA, rd_valid
  );
endinterface

// File: rtl/ssp_fifo_mem.sv
// FIFO storage: one write port and a registered read port, no reset so the
// array maps onto plain RAM/flops without clear logic.
module ssp_fifo_mem
  import ssp_pkg::*;
#(
  parameter int DATA_W = SSP_DATA_W,
  parameter int DEPTH  = SSP_RXFIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata_r
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; a simultaneous write to the same slot returns the old entry
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/ssp_rx_fifo_wm.sv
// SSP receive FIFO with watermark, sticky overrun and receive-timeout interrupts.
// Pointers, occupancy, flags and the timeout counter live here; storage is in ssp_fifo_mem.
module ssp_rx_fifo_wm
  import ssp_pkg::*;
#(
  parameter int DATA_W  = SSP_DATA_W,
  parameter int DEPTH   = SSP_RXFIFO_DEPTH,
  parameter int TIMEOUT = SSP_RX_TIMEOUT,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               PCLK,
  input  logic               CLEAR_B,
  ssp_rx_fifo_wm_if.slave    bus,
  input  logic [CNT_W-1:0]   rx_thresh,
  input  logic               ror_clr,
  output logic [CNT_W-1:0]   rx_count,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic               SSPRXINTR,
  output logic               SSPRORINTR,
  output logic               SSPRTINTR
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int IDLE_W = clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [IDLE_W-1:0] TIMEOUT_C = IDLE_W'(TIMEOUT);

  logic [PTR_W-1:0]  wptr_r;
  logic [PTR_W-1:0]  rptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [IDLE_W-1:0] idle_r;
  logic              rd_valid_r;
  logic              ror_r;
  logic [DATA_W-1:0] mem_rdata_r;

  logic empty_s;
  logic full_s;
  logic push_s;
  logic pop_s;
  logic ovr_s;

  // A threshold of zero, or one beyond the depth, means "interrupt only when full"
  function automatic logic [CNT_W-1:0] eff_thresh(input logic [CNT_W-1:0] th);
    if ((th == {CNT_W{1'b0}}) || (th > DEPTH_C)) begin
      return DEPTH_C;
    end else begin
      return th;
    end
  endfunction

  // Push/pop/overrun decode; a pop frees the slot a same-cycle push lands in
  always_comb begin
    empty_s = (count_r == {CNT_W{1'b0}});
    full_s  = (count_r == DEPTH_C);
    pop_s   = bus.PSEL && !bus.PWRITE && !empty_s;
    push_s  = bus.write_ready && (!full_s || pop_s);
    ovr_s   = bus.write_ready && full_s && !pop_s;
  end

  ssp_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (PCLK),
    .we      (push_s),
    .waddr   (wptr_r),
    .wdata   (bus.RxData),
    .re      (pop_s),
    .raddr   (rptr_r),
    .rdata_r (mem_rdata_r)
  );

  // Pointers and occupancy
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wptr_r  <= {PTR_W{1'b0}};
      rptr_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rptr_r <= rptr_r + PTR_W'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1'b1);
        2'b01:   count_r <= count_r - CNT_W'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Read strobe and sticky overrun; a new drop outranks a same-cycle clear
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      rd_valid_r <= 1'b0;
      ror_r      <= 1'b0;
    end else begin
      rd_valid_r <= pop_s;
      if (ovr_s) begin
        ror_r <= 1'b1;
      end else if (ror_clr) begin
        ror_r <= 1'b0;
      end
    end
  end

  // Idle counter for the receive timeout, saturating at TIMEOUT
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      idle_r <= {IDLE_W{1'b0}};
    end else if (push_s || pop_s || empty_s) begin
      idle_r <= {IDLE_W{1'b0}};
    end else if (idle_r != TIMEOUT_C) begin
      idle_r <= idle_r + IDLE_W'(1'b1);
    end
  end

  // Outputs are decoded from registers only
  always_comb begin
    bus.PRDATA   = rd_valid_r ? mem_rdata_r : {DATA_W{1'b0}};
    bus.rd_valid = rd_valid_r;
    rx_count     = count_r;
    fifo_empty   = empty_s;
    fifo_full    = full_s;
    SSPRXINTR    = (count_r >= eff_thresh(rx_thresh));
    SSPRORINTR   = ror_r;
    SSPRTINTR    = (idle_r == TIMEOUT_C) && !empty_s;
  end

endmodule

// File: tb/tb_ssp_rx_fifo_wm.sv
// Directed bench for ssp_rx_fifo_wm: a queue-based reference model checked on every
// falling edge, plus literal expectations for popped data, timeout latency and flags.
module tb_ssp_rx_fifo_wm;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int TO    = 32;
  localparam int CW    = 4;

  logic          PCLK = 1'b0;
  logic          CLEAR_B;
  logic [CW-1:0] rx_thresh;
  logic          ror_clr;
  logic [CW-1:0] rx_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic          rxi;
  logic          rori;
  logic          rti;

  ssp_rx_fifo_wm_if #(.DATA_W(DW)) bus ();

  ssp_rx_fifo_wm #(
    .DATA_W  (DW),
    .DEPTH   (DEPTH),
    .TIMEOUT (TO)
  ) dut (
    .PCLK       (PCLK),
    .CLEAR_B    (CLEAR_B),
    .bus        (bus),
    .rx_thresh  (rx_thresh),
    .ror_clr    (ror_clr),
    .rx_count   (rx_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .SSPRXINTR  (rxi),
    .SSPRORINTR (rori),
    .SSPRTINTR  (rti)
  );

  always #5 PCLK = ~PCLK;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [7:0] q[$];
  logic [7:0] dut_log[$];
  logic [7:0] exp_log[$];
  bit         m_ror;
  bit         m_rdv;
  logic [7:0] m_prd;
  int         m_idle;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int m_thresh();
    int t;
    t = int'(rx_thresh);
    return ((t == 0) || (t > DEPTH)) ? DEPTH : t;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ror  = 1'b0;
    m_rdv  = 1'b0;
    m_prd  = 8'h00;
    m_idle = 0;
  endtask

  // Reference behaviour of one clock edge, from the inputs held across it
  task automatic model_step();
    bit empty0;
    bit full0;
    bit pop;
    bit push;
    empty0 = (q.size() == 0);
    full0  = (q.size() == DEPTH);
    pop    = bus.PSEL && !bus.PWRITE && !empty0;
    push   = bus.write_ready && (!full0 || pop);
    if (pop) begin
      m_prd = q.pop_front();
      m_rdv = 1'b1;
    end else begin
      m_prd = 8'h00;
      m_rdv = 1'b0;
    end
    if (push) q.push_back(bus.RxData);
    if (bus.write_ready && !push) m_ror = 1'b1;
    else if (ror_clr) m_ror = 1'b0;
    if (push || pop || empty0) m_idle = 0;
    else if (m_idle < TO) m_idle++;
  endtask

  always @(negedge PCLK) begin
    if (chk_en) begin
      chk("rx_count",   32'(rx_count),     32'(q.size()));
      chk("fifo_empty", 32'(fifo_empty),   32'(q.size() == 0));
      chk("fifo_full",  32'(fifo_full),    32'(q.size() == DEPTH));
      chk("SSPRXINTR",  32'(rxi),          32'(q.size() >= m_thresh()));
      chk("SSPRORINTR", 32'(rori),         32'(m_ror));
      chk("SSPRTINTR",  32'(rti),          32'((m_idle == TO) && (q.size() > 0)));
      chk("rd_valid",   32'(bus.rd_valid), 32'(m_rdv));
      chk("PRDATA",     32'(bus.PRDATA),   32'(m_prd));
    end
  end

  // One clock cycle; entered and left at 1 time unit after a rising edge
  task automatic cyc(input bit wr, input logic [7:0] d, input bit rd,
                     input bit pw = 1'b0, input bit clr = 1'b0);
    bus.write_ready = wr;
    bus.RxData      = d;
    bus.PSEL        = rd;
    bus.PWRITE      = pw;
    ror_clr         = clr;
    @(posedge PCLK);
    model_step();
    #1;
    if (bus.rd_valid) dut_log.push_back(bus.PRDATA);
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_len"}, 32'(dut_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size(); i++) begin
      if (i < dut_log.size()) chk(nm, 32'(dut_log[i]), 32'(exp_log[i]));
    end
    dut_log.delete();
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_count"}, 32'(rx_count), 32'd0);
    chk({nm, "_empty"}, 32'(fifo_empty), 32'd1);
    chk({nm, "_full"},  32'(fifo_full), 32'd0);
    chk({nm, "_rxi"},   32'(rxi), 32'd0);
    chk({nm, "_rori"},  32'(rori), 32'd0);
    chk({nm, "_rti"},   32'(rti), 32'd0);
    chk({nm, "_rdv"},   32'(bus.rd_valid), 32'd0);
    chk({nm, "_prdata"}, 32'(bus.PRDATA), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int first;
    CLEAR_B         = 1'b1;
    rx_thresh       = 4'd0;
    ror_clr         = 1'b0;
    bus.write_ready = 1'b0;
    bus.RxData      = 8'h00;
    bus.PSEL        = 1'b0;
    bus.PWRITE      = 1'b0;
    model_reset();

    // Reset asserted mid-cycle
    #8;
    CLEAR_B = 1'b0;
    #1;
    chk_reset_vals("reset");
    @(posedge PCLK);
    #1;
    CLEAR_B = 1'b1;
    chk_en  = 1'b1;

    // Fill, partial drain, refill across the wrap, full drain
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h11 + 8'(i), 1'b0);
    chk("fill_full", 32'(fifo_full), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'hA1 + 8'(i), 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    chk("drain_empty", 32'(fifo_empty), 32'd1);
    exp_log = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18,
                8'hA1, 8'hA2, 8'hA3};
    chk_log("fill_drain");

    // Overrun drops the entry and sets the sticky flag; APB writes never pop
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h21 + 8'(i), 1'b0);
    cyc(1'b1, 8'h55, 1'b0);
    chk("ovr_flag", 32'(rori), 32'd1);
    chk("ovr_count", 32'(rx_count), 32'd8);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    chk("apb_write_no_pop", 32'(rx_count), 32'd8);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("ovr_sticky", 32'(rori), 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovr_clear", 32'(rori), 32'd0);
    exp_log = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
    chk_log("ovr_drain");

    // Simultaneous push and pop on a full FIFO
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h31 + 8'(i), 1'b0);
    cyc(1'b1, 8'h77, 1'b1);
    chk("both_full_count", 32'(rx_count), 32'd8);
    chk("both_full_noovr", 32'(rori), 32'd0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    exp_log = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h77};
    chk_log("both_full");

    // Watermark at 3, then threshold 0 meaning full
    rx_thresh = 4'd3;
    cyc(1'b1, 8'h01, 1'b0);
    cyc(1'b1, 8'h02, 1'b0);
    chk("wm3_at2", 32'(rxi), 32'd0);
    cyc(1'b1, 8'h03, 1'b0);
    chk("wm3_at3", 32'(rxi), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("wm3_pop", 32'(rxi), 32'd0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    rx_thresh = 4'd0;
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'h40 + 8'(i), 1'b0);
    chk("wm0_at7", 32'(rxi), 32'd0);
    cyc(1'b1, 8'h47, 1'b0);
    chk("wm0_at8", 32'(rxi), 32'd1);
    rx_thresh = 4'd12;
    #1;
    chk("wm12_as_full", 32'(rxi), 32'd1);
    rx_thresh = 4'd0;
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    dut_log.delete();

    // Receive timeout: exactly TIMEOUT edges after the last push
    cyc(1'b1, 8'h99, 1'b0);
    first = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      if (rti && (first == 0)) first = i;
    end
    chk("timeout_edges", 32'(first), 32'd32);
    cyc(1'b0, 8'h00, 1'b1);
    chk("timeout_pop_rti", 32'(rti), 32'd0);
    chk("timeout_pop_empty", 32'(fifo_empty), 32'd1);
    for (int i = 0; i < 40; i++) cyc(1'b0, 8'h00, 1'b0);
    chk("timeout_empty_rti", 32'(rti), 32'd0);
    dut_log.delete();

    // Reset during a pop discards everything in flight
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'h61 + 8'(i), 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("pre_reset_rdv", 32'(bus.rd_valid), 32'd1);
    #2;
    chk_en  = 1'b0;
    CLEAR_B = 1'b0;
    #1;
    chk_reset_vals("midreset");
    model_reset();
    @(posedge PCLK);
    #1;
    CLEAR_B = 1'b1;
    chk_en  = 1'b1;
    dut_log.delete();
    cyc(1'b1, 8'h42, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    exp_log = '{8'h42};
    chk_log("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
